dmac_ch_sched: RTL and testbench

Multi-channel scheduler for the single-channel AHB-Lite DMA master engine. It holds one pending flag per channel and arbitrates among requesting channels round-robin. It drives the winner's descriptor onto the master's configuration inputs and launches the transfer with a one-cycle `start`. It tracks completion into per-channel sticky status bits and a combined interrupt, and sits between the register file that holds the channel descriptors and the master engine.

---
 rtl/dmac_pkg.sv | 29 ++
 rtl/dmac_ch_sched_if.sv | 34 +++
 rtl/dmac_rr_arb.sv | 35 +++
 rtl/dmac_ch_sched.sv | 144 ++++++++++++++
 tb/tb_dmac_ch_sched.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA controller: scheduler state encoding,
// field widths and the per-channel descriptor payload.
package dmac_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SZ_W   = 3;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } sched_state_t;

    // One channel's transfer descriptor as presented to the master engine.
    typedef struct packed {
        logic [ADDR_W-1:0] saddr;
        logic [ADDR_W-1:0] daddr;
        logic [SZ_W-1:0]   ssize;
        logic [SZ_W-1:0]   dsize;
        logic [SZ_W-1:0]   sinc;
        logic [SZ_W-1:0]   dinc;
        logic [SZ_W-1:0]   irqsrc;
        logic [CNT_W-1:0]  bsize;
        logic [CNT_W-1:0]  bcount;
        logic              wfi;
    } desc_t;

endpackage

// File: rtl/dmac_ch_sched_if.sv
// Scheduler <-> master engine link: descriptor fields, launch pulse and
// completion/busy status.
//   master modport : scheduler side (drives descriptor and m_start)
//   slave  modport : DMA master engine side (drives m_done, m_busy)
interface dmac_ch_sched_if;
    import dmac_pkg::*;

    logic [ADDR_W-1:0] m_saddr;
    logic [ADDR_W-1:0] m_daddr;
    logic [SZ_W-1:0]   m_ssize;
    logic [SZ_W-1:0]   m_dsize;
    logic [SZ_W-1:0]   m_sinc;
    logic [SZ_W-1:0]   m_dinc;
    logic [SZ_W-1:0]   m_irqsrc;
    logic [CNT_W-1:0]  m_bsize;
    logic [CNT_W-1:0]  m_bcount;
    logic              m_wfi;
    logic              m_start;
    logic              m_done;
    logic              m_busy;

    modport master (
        output m_saddr, m_daddr, m_ssize, m_dsize, m_sinc, m_dinc, m_irqsrc,
               m_bsize, m_bcount, m_wfi, m_start,
        input  m_done, m_busy
    );

    modport slave (
        input  m_saddr, m_daddr, m_ssize, m_dsize, m_sinc, m_dinc, m_irqsrc,
               m_bsize, m_bcount, m_wfi, m_start,
        output m_done, m_busy
    );

endinterface

// File: rtl/dmac_rr_arb.sv
// Combinational rotating-priority encoder: returns the first asserted req
// bit searching ptr, ptr+1, ... wrapping modulo NCH.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   gnt_valid : any request present
//   gnt_idx   : winning index
module dmac_rr_arb #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic           gnt_valid,
    output logic [CW-1:0]  gnt_idx
);

    int unsigned idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!gnt_valid && req[CW'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = CW'(idx);
            end
        end
    end

endmodule

// File: rtl/dmac_ch_sched.sv
// Multi-channel round-robin scheduler in front of the single-channel DMA
// master. Latches per-channel triggers as pending flags, grants one eligible
// channel at a time, presents its descriptor to the master, launches it with
// a one-cycle m_start and records completion in sticky done bits.
//   HCLK, HRESET       : clock, synchronous active-high reset
//   ch_*  descriptors  : packed per-channel descriptor fields from registers
//   ch_en/ch_ie        : arbitration enable / interrupt enable per channel
//   ch_req/stat_clr    : trigger pulse / done-bit clear pulse per channel
//   m                  : link to the master engine (master modport)
//   ch_pend/ch_done    : pending flags / sticky completion status
//   act_valid/act_ch   : channel currently owning the master
//   irq                : registered OR of enabled done bits
module dmac_ch_sched
    import dmac_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = $clog2(NCH)
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [NCH*ADDR_W-1:0] ch_saddr,
    input  logic [NCH*ADDR_W-1:0] ch_daddr,
    input  logic [NCH*SZ_W-1:0]   ch_ssize,
    input  logic [NCH*SZ_W-1:0]   ch_dsize,
    input  logic [NCH*SZ_W-1:0]   ch_sinc,
    input  logic [NCH*SZ_W-1:0]   ch_dinc,
    input  logic [NCH*SZ_W-1:0]   ch_irqsrc,
    input  logic [NCH*CNT_W-1:0]  ch_bsize,
    input  logic [NCH*CNT_W-1:0]  ch_bcount,
    input  logic [NCH-1:0]        ch_wfi,
    input  logic [NCH-1:0]        ch_en,
    input  logic [NCH-1:0]        ch_ie,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        stat_clr,
    dmac_ch_sched_if.master       m,
    output logic [NCH-1:0]        ch_pend,
    output logic [NCH-1:0]        ch_done,
    output logic                  act_valid,
    output logic [CW-1:0]         act_ch,
    output logic                  irq
);

    sched_state_t   state;
    logic [CW-1:0]  rr;
    logic [NCH-1:0] elig;
    logic           gnt_valid;
    logic [CW-1:0]  gnt_idx;
    logic [NCH-1:0] cmpl_mask;
    desc_t          sel;

    assign elig = ch_pend & ch_en;

    dmac_rr_arb #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .req       (elig),
        .ptr       (rr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // One-hot of the channel finishing this cycle; empty outside RUN.
    assign cmpl_mask = (state == ST_RUN && m.m_done) ? (NCH'(1) << act_ch) : '0;

    // Descriptor mux driven only by registered act_ch, so m_done/m_busy never
    // reach the descriptor outputs. act_ch is 0 whenever idle.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (act_ch == CW'(i)) begin
                sel.saddr  = ch_saddr [ADDR_W*i +: ADDR_W];
                sel.daddr  = ch_daddr [ADDR_W*i +: ADDR_W];
                sel.ssize  = ch_ssize [SZ_W*i   +: SZ_W];
                sel.dsize  = ch_dsize [SZ_W*i   +: SZ_W];
                sel.sinc   = ch_sinc  [SZ_W*i   +: SZ_W];
                sel.dinc   = ch_dinc  [SZ_W*i   +: SZ_W];
                sel.irqsrc = ch_irqsrc[SZ_W*i   +: SZ_W];
                sel.bsize  = ch_bsize [CNT_W*i  +: CNT_W];
                sel.bcount = ch_bcount[CNT_W*i  +: CNT_W];
                sel.wfi    = ch_wfi[i];
            end
        end
    end

    assign m.m_saddr  = sel.saddr;
    assign m.m_daddr  = sel.daddr;
    assign m.m_ssize  = sel.ssize;
    assign m.m_dsize  = sel.dsize;
    assign m.m_sinc   = sel.sinc;
    assign m.m_dinc   = sel.dinc;
    assign m.m_irqsrc = sel.irqsrc;
    assign m.m_bsize  = sel.bsize;
    assign m.m_bcount = sel.bcount;
    assign m.m_wfi    = sel.wfi;

    // Launch pulse: state decode gated by the master's busy flag.
    assign m.m_start = (state == ST_LAUNCH) && !m.m_busy;

    // Scheduler state, flags and interrupt.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            rr        <= '0;
            act_valid <= 1'b0;
            act_ch    <= '0;
            ch_pend   <= '0;
            ch_done   <= '0;
            irq       <= 1'b0;
        end else begin
            // Re-trigger beats completion clear; completion beats stat_clr.
            ch_pend <= (ch_pend & ~cmpl_mask) | ch_req;
            ch_done <= (ch_done & ~stat_clr) | cmpl_mask;
            irq     <= |(ch_done & ch_ie);

            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        act_ch    <= gnt_idx;
                        act_valid <= 1'b1;
                        rr        <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (!m.m_busy) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (m.m_done) begin
                        act_valid <= 1'b0;
                        act_ch    <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmac_ch_sched.sv
// Directed bench for dmac_ch_sched: request latency, descriptor hold,
// round-robin order, busy gating, collisions, enable masking, reset mid-run.
module tb_dmac_ch_sched;
    import dmac_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 2;

    logic                  HCLK;
    logic                  HRESET;
    logic [NCH*ADDR_W-1:0] ch_saddr, ch_daddr;
    logic [NCH*SZ_W-1:0]   ch_ssize, ch_dsize, ch_sinc, ch_dinc, ch_irqsrc;
    logic [NCH*CNT_W-1:0]  ch_bsize, ch_bcount;
    logic [NCH-1:0]        ch_wfi, ch_en, ch_ie, ch_req, stat_clr;
    logic [NCH-1:0]        ch_pend, ch_done;
    logic                  act_valid;
    logic [CW-1:0]         act_ch;
    logic                  irq;

    int checks = 0;
    int errors = 0;

    dmac_ch_sched_if m_if ();

    dmac_ch_sched #(.NCH(NCH), .CW(CW)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .ch_saddr  (ch_saddr),
        .ch_daddr  (ch_daddr),
        .ch_ssize  (ch_ssize),
        .ch_dsize  (ch_dsize),
        .ch_sinc   (ch_sinc),
        .ch_dinc   (ch_dinc),
        .ch_irqsrc (ch_irqsrc),
        .ch_bsize  (ch_bsize),
        .ch_bcount (ch_bcount),
        .ch_wfi    (ch_wfi),
        .ch_en     (ch_en),
        .ch_ie     (ch_ie),
        .ch_req    (ch_req),
        .stat_clr  (stat_clr),
        .m         (m_if),
        .ch_pend   (ch_pend),
        .ch_done   (ch_done),
        .act_valid (act_valid),
        .act_ch    (act_ch),
        .irq       (irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] saddr_of(input int ch);
        return 32'h1000_0000 + 32'(ch) * 32'h100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
    endtask

    // Wait (bounded) for a launch, check the owner, then complete it.
    task automatic serve(input string tag, input int ch);
        int n;
        n = 0;
        while (!m_if.m_start && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_start"}, 32'(m_if.m_start), 32'd1);
        chk({tag, "_ch"}, 32'(act_ch), 32'(ch));
        chk({tag, "_saddr"}, m_if.m_saddr, saddr_of(ch));
        tick();
        m_if.m_done = 1'b1;
        tick();
        m_if.m_done = 1'b0;
    endtask

    initial begin
        int bad;
        HRESET      = 1'b1;
        ch_req      = '0;
        stat_clr    = '0;
        ch_en       = 4'b1111;
        ch_ie       = 4'b1111;
        ch_wfi      = 4'b1010;
        m_if.m_done = 1'b0;
        m_if.m_busy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            ch_saddr [32*i +: 32] = saddr_of(i);
            ch_daddr [32*i +: 32] = 32'h2000_0000 + 32'(i) * 32'h40;
            ch_ssize [3*i +: 3]   = 3'(i);
            ch_dsize [3*i +: 3]   = 3'(i + 1);
            ch_sinc  [3*i +: 3]   = 3'd1;
            ch_dinc  [3*i +: 3]   = 3'd2;
            ch_irqsrc[3*i +: 3]   = 3'(7 - i);
            ch_bsize [8*i +: 8]   = 8'(16 + i);
            ch_bcount[8*i +: 8]   = 8'(3 * i + 5);
        end

        // Reset values
        do_reset();
        chk("rst_pend", 32'(ch_pend), 32'd0);
        chk("rst_done", 32'(ch_done), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_act_valid", 32'(act_valid), 32'd0);
        chk("rst_act_ch", 32'(act_ch), 32'd0);
        chk("rst_start", 32'(m_if.m_start), 32'd0);
        chk("rst_saddr_ch0", m_if.m_saddr, saddr_of(0));

        // Single channel: req at t, start at t+2, done at t+20
        ch_req = 4'b0100;
        tick();
        ch_req = '0;
        chk("s_pend_t1", 32'(ch_pend), 32'h4);
        chk("s_start_t1", 32'(m_if.m_start), 32'd0);
        tick();
        chk("s_start_t2", 32'(m_if.m_start), 32'd1);
        chk("s_act_ch", 32'(act_ch), 32'd2);
        chk("s_act_valid", 32'(act_valid), 32'd1);
        chk("s_saddr", m_if.m_saddr, saddr_of(2));
        chk("s_bcount", 32'(m_if.m_bcount), 32'd11);
        chk("s_wfi", 32'(m_if.m_wfi), 32'd0);
        bad = 0;
        for (int k = 3; k <= 20; k++) begin
            tick();
            if (m_if.m_saddr !== saddr_of(2) || m_if.m_start !== 1'b0) bad++;
        end
        chk("s_hold", 32'(bad), 32'd0);
        m_if.m_done = 1'b1;
        tick();
        m_if.m_done = 1'b0;
        chk("s_done_t21", 32'(ch_done), 32'h4);
        chk("s_pend_t21", 32'(ch_pend), 32'h0);
        chk("s_act_valid_t21", 32'(act_valid), 32'd0);
        chk("s_irq_t21", 32'(irq), 32'd0);
        tick();
        chk("s_irq_t22", 32'(irq), 32'd1);
        stat_clr = 4'b0100;
        tick();
        stat_clr = '0;
        chk("s_clr_done", 32'(ch_done), 32'h0);
        chk("s_irq_lag", 32'(irq), 32'd1);
        tick();
        chk("s_irq_off", 32'(irq), 32'd0);

        // Round-robin from rr=0
        do_reset();
        ch_req = 4'b1111;
        tick();
        ch_req = '0;
        serve("rr0", 0);
        serve("rr1", 1);
        serve("rr2", 2);
        serve("rr3", 3);
        chk("rr_done_all", 32'(ch_done), 32'hF);
        ch_req = 4'b1010;
        tick();
        ch_req = '0;
        serve("rr_b1", 1);
        serve("rr_b3", 3);

        // Busy gating: held in LAUNCH for 5 cycles, single start on release
        m_if.m_busy = 1'b1;
        ch_req = 4'b0001;
        tick();
        ch_req = '0;
        tick();
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (m_if.m_start !== 1'b0 || act_valid !== 1'b1) bad++;
            tick();
        end
        chk("busy_hold", 32'(bad), 32'd0);
        m_if.m_busy = 1'b0;
        #1;
        chk("busy_start", 32'(m_if.m_start), 32'd1);
        chk("busy_ch", 32'(act_ch), 32'd0);
        tick();
        chk("busy_single", 32'(m_if.m_start), 32'd0);
        m_if.m_done = 1'b1;
        tick();
        m_if.m_done = 1'b0;

        // Collisions: re-trigger and stat_clr in channel 1's completion cycle
        stat_clr = 4'b1111;
        tick();
        stat_clr = '0;
        ch_req = 4'b0010;
        tick();
        ch_req = '0;
        begin
            int n;
            n = 0;
            while (!m_if.m_start && n < 20) begin
                tick();
                n++;
            end
        end
        chk("col_ch", 32'(act_ch), 32'd1);
        tick();
        m_if.m_done = 1'b1;
        ch_req      = 4'b0010;
        stat_clr    = 4'b0010;
        tick();
        m_if.m_done = 1'b0;
        ch_req      = '0;
        stat_clr    = '0;
        chk("col_pend", 32'(ch_pend), 32'h2);
        chk("col_done", 32'(ch_done), 32'h2);
        serve("col_relaunch", 1);

        // Enable masking: channel 1 skipped until re-enabled
        do_reset();
        ch_en  = 4'b1101;
        ch_req = 4'b1111;
        tick();
        ch_req = '0;
        serve("en0", 0);
        serve("en2", 2);
        serve("en3", 3);
        tick();
        tick();
        chk("en_pend_kept", 32'(ch_pend), 32'h2);
        chk("en_idle", 32'(act_valid), 32'd0);
        ch_en = 4'b1111;
        serve("en1", 1);
        tick();
        chk("en_irq", 32'(irq), 32'd1);

        // Reset mid-RUN, then a stray m_done
        ch_req = 4'b0100;
        tick();
        ch_req = '0;
        tick();
        chk("mr_start", 32'(m_if.m_start), 32'd1);
        tick();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        chk("mr_pend", 32'(ch_pend), 32'd0);
        chk("mr_done", 32'(ch_done), 32'd0);
        chk("mr_irq", 32'(irq), 32'd0);
        chk("mr_act_valid", 32'(act_valid), 32'd0);
        chk("mr_act_ch", 32'(act_ch), 32'd0);
        chk("mr_start_off", 32'(m_if.m_start), 32'd0);
        m_if.m_done = 1'b1;
        tick();
        m_if.m_done = 1'b0;
        tick();
        chk("mr_stray_done", 32'(ch_done), 32'd0);
        chk("mr_stray_pend", 32'(ch_pend), 32'd0);
        chk("mr_stray_act", 32'(act_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
